instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Fetch stage and IF/ID pipeline register of the MIPS core.
- Sits directly upstream of the instruction decoder, which takes its opcode from instr_o[31:26].
- Owns the PC and drives the asynchronous instruction-memory address.
- Handles stall from the hazard unit, redirect (taken branch or jump) from the branch/jump resolve logic, and halt.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- PC_W, 32: PC and instruction width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- stall_i  in  1  hold PC and IF/ID register.
- redirect_i  in  1  load PC from redirect_pc_i and flush IF/ID.
- redirect_pc_i  in  PC_W  redirect target.
- halt_i  in  1  stop fetching permanently, until reset.
- imem_addr_o  out  PC_W  instruction-memory address; combinational copy of pc_q.
- imem_data_i  in  PC_W  instruction word; combinational read of imem_addr_o.
- instr_o  out  PC_W  IF/ID instruction; bubble value is 32'h0000_0000 (NOP).
- pc_o  out  PC_W  IF/ID PC of instr_o.
- pc_plus4_o  out  PC_W  IF/ID pc_o+4, used by JAL link and branch target adders.
- valid_o  out  1  IF/ID holds a real instruction.
- misalign_o  out  1  sticky flag: a redirect target had bits [1:0] nonzero.
- state_o  out  2  FSM state, for debug.

Behaviour:
- Reset (rst_i=1 at a clock edge): pc_q=RESET_PC; instr_o=0; pc_o=0; pc_plus4_o=0; valid_o=0; misalign_o=0; state=BOOT.
  - Reset overrides every other input.
  - Reset arriving mid-stall, mid-redirect or in HALT behaves identically.
- States: BOOT=0, RUN=1, HALT=2. Encoding 3 is unused; treat it as BOOT.
- BOOT: lasts one cycle. PC is held, IF/ID is a bubble, all inputs are ignored. Next state is RUN unconditionally.
- RUN: per-edge priority is halt_i > redirect_i > stall_i > normal.
  - normal: pc_q<=pc_q+4; instr_o<=imem_data_i; pc_o<=pc_q; pc_plus4_o<=pc_q+4; valid_o<=1.
  - stall_i: pc_q and all IF/ID outputs hold their values, including valid_o.
  - redirect_i: pc_q<={redirect_pc_i[31:2],2'b00}; IF/ID becomes a bubble (instr_o=0, valid_o=0, pc_o and pc_plus4_o hold). A redirect overrides a stall in the same cycle.
  - misalign_o is set if redirect_i=1 and redirect_pc_i[1:0]!=0. It clears only on reset.
  - halt_i: next state is HALT; IF/ID becomes a bubble; pc_q holds.
- HALT: pc_q held, IF/ID bubble every cycle, all inputs ignored. Exit only via reset.
- Latency: the instruction at PC appears on instr_o one edge after pc_q=PC, provided there is no stall.
- Arithmetic: PC+4 is modulo 2^PC_W. 32'hFFFF_FFFC wraps to 0 silently.
- imem_addr_o always equals pc_q, including in HALT and BOOT.

Optional Feature:
- Macro: INSTR_FETCH_PERF_EN.
- When defined: adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0].
  - stall_cnt_o counts RUN cycles where stall_i=1, redirect_i=0 and halt_i=0.
  - flush_cnt_o counts RUN cycles where redirect_i=1 and halt_i=0.
  - Both reset to 0, saturate at 32'hFFFF_FFFF, and do not count in BOOT or HALT.
- When undefined: neither port exists and no counter logic is generated.

Decomposition:
- Shared package cpu_pkg holds:
  - NOP_INSTR=32'h0
  - OPCODE_W=6
  - fetch state typedef (BOOT/RUN/HALT)
  - default RESET_PC
- One sub-module: if_id_reg, the IF/ID register with load, hold and bubble controls. The PC and FSM stay in instr_fetch.

Test Plan:
- Reset then run, imem returns addr|32'h2000_0000: cycle 1 after reset gives valid_o=0 (BOOT). Then instr_o=32'h2000_0000 with pc_o=0, next 32'h2000_0004 with pc_o=4, and pc_plus4_o=pc_o+4 throughout.
- stall_i=1 for 3 cycles at pc_q=8: imem_addr_o stays 8, and instr_o/pc_o=4/valid_o=1 hold for 3 cycles. Fetch resumes with pc_o=8.
- redirect_i=1, redirect_pc_i=32'h40, stall_i=1 in the same cycle: next edge gives valid_o=0, instr_o=0, imem_addr_o=32'h40. Following edge gives pc_o=32'h40, valid_o=1.
- redirect_pc_i=32'h43: pc_q=32'h40, misalign_o=1 and it stays 1 until rst_i.
- Start at RESET_PC=32'hFFFF_FFF8 and run: pc_o sequence FFFF_FFF8, FFFF_FFFC, 0000_0000 with no error.
- halt_i=1, then redirect_i=1 next cycle: valid_o=0 forever, pc_q frozen, state_o=2. Then rst_i=1 gives state_o=0 and pc_q=RESET_PC. With INSTR_FETCH_PERF_EN, the counters match the stall and redirect cycles that were driven.

Source files
------------

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the MIPS core front end.
//   NOP_INSTR        : instruction word used as a pipeline bubble
//   OPCODE_W         : width of the opcode field instr[31:26] seen by decode
//   DEFAULT_RESET_PC : PC loaded on reset unless the fetch stage overrides it
//   fetch_state_e    : fetch FSM states (BOOT/RUN/HALT); encoding 3 unused
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam int unsigned OPCODE_W         = 6;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register. Bubble has priority over load; with neither
// asserted every field holds (stall).
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   load_i              : capture instr/pc/pc+4 and mark valid
//   bubble_i            : insert NOP, clear valid, keep pc/pc+4
//   instr_d_i, pc_d_i, pc_plus4_d_i : values captured on load
//   instr_o, pc_o, pc_plus4_o, valid_o : registered IF/ID contents
// ---------------------------------------------------------------------------
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         bubble_i,
  input  logic [W-1:0] instr_d_i,
  input  logic [W-1:0] pc_d_i,
  input  logic [W-1:0] pc_plus4_d_i,
  output logic [W-1:0] instr_o,
  output logic [W-1:0] pc_o,
  output logic [W-1:0] pc_plus4_o,
  output logic         valid_o
);

  // A bubble only replaces the instruction and valid bit; pc/pc+4 keep
  // their last value so debug and link logic see a stable PC.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_o    <= W'(NOP_INSTR);
      pc_o       <= '0;
      pc_plus4_o <= '0;
      valid_o    <= 1'b0;
    end else if (bubble_i) begin
      instr_o <= W'(NOP_INSTR);
      valid_o <= 1'b0;
    end else if (load_i) begin
      instr_o    <= instr_d_i;
      pc_o       <= pc_d_i;
      pc_plus4_o <= pc_plus4_d_i;
      valid_o    <= 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Fetch stage of the MIPS core: owns the PC and fetch FSM, drives the
// asynchronous instruction memory and feeds the IF/ID register.
// Parameters: PC_W (PC/instruction width), RESET_PC (word aligned).
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   stall_i                 : hold PC and IF/ID
//   redirect_i, redirect_pc_i : taken branch/jump; load PC, flush IF/ID
//   halt_i                  : stop fetching until reset
//   imem_addr_o, imem_data_i: instruction memory address / read data
//   instr_o, pc_o, pc_plus4_o, valid_o : IF/ID contents
//   misalign_o              : sticky, a redirect target was not word aligned
//   state_o                 : fetch FSM state for debug
// Optional: define INSTR_FETCH_PERF_EN to add stall_cnt_o / flush_cnt_o,
// saturating counters of stall and flush cycles seen in RUN.
// ---------------------------------------------------------------------------
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned      PC_W     = 32,
  parameter logic [PC_W-1:0]  RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  input  logic            halt_i,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic [PC_W-1:0] imem_data_i,
  output logic [PC_W-1:0] instr_o,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] pc_plus4_o,
  output logic            valid_o,
  output logic            misalign_o,
`ifdef INSTR_FETCH_PERF_EN
  output logic [31:0]     stall_cnt_o,
  output logic [31:0]     flush_cnt_o,
`endif
  output logic [1:0]      state_o
);

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_plus4;
  logic            misalign_q, misalign_d;
  logic            load_ifid, bubble_ifid;

  // Wraps modulo 2^PC_W by construction.
  assign pc_plus4    = pc_q + PC_STEP;
  assign imem_addr_o = pc_q;
  assign misalign_o  = misalign_q;
  assign state_o     = state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  // Next-state and IF/ID control. In RUN the priority is
  // halt > redirect > stall > sequential fetch. The unused encoding falls
  // into the default arm and behaves like BOOT.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    misalign_d  = misalign_q;
    load_ifid   = 1'b0;
    bubble_ifid = 1'b0;
    case (state_q)
      RUN: begin
        if (halt_i) begin
          state_d     = HALT;
          bubble_ifid = 1'b1;
        end else if (redirect_i) begin
          pc_d        = {redirect_pc_i[PC_W-1:2], 2'b00};
          bubble_ifid = 1'b1;
          if (redirect_pc_i[1:0] != 2'b00) begin
            misalign_d = 1'b1;
          end
        end else if (!stall_i) begin
          pc_d      = pc_plus4;
          load_ifid = 1'b1;
        end
      end
      HALT: begin
        bubble_ifid = 1'b1;
      end
      default: begin
        state_d     = RUN;
        bubble_ifid = 1'b1;
      end
    endcase
  end

  if_id_reg #(
    .W (PC_W)
  ) u_if_id_reg (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .load_i       (load_ifid),
    .bubble_i     (bubble_ifid),
    .instr_d_i    (imem_data_i),
    .pc_d_i       (pc_q),
    .pc_plus4_d_i (pc_plus4),
    .instr_o      (instr_o),
    .pc_o         (pc_o),
    .pc_plus4_o   (pc_plus4_o),
    .valid_o      (valid_o)
  );

`ifdef INSTR_FETCH_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;
  logic        stall_evt, flush_evt;

  assign stall_evt = (state_q == RUN) && stall_i && !redirect_i && !halt_i;
  assign flush_evt = (state_q == RUN) && redirect_i && !halt_i;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_evt && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (flush_evt && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
